// File: rtl/cpu_defs_pkg.sv
// Shared CPU-level definitions: memory-port identifiers, bus arbiter states
// and cache line geometry.
package cpu_defs;

    localparam int LINE_BEATS = 4;

    typedef enum logic {
        MEM_PORT_IC = 1'b0,
        MEM_PORT_DC = 1'b1
    } mem_port_t;

    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_ADDR  = 3'd1,
        ARB_RDATA = 3'd2,
        ARB_WDATA = 3'd3,
        ARB_WRESP = 3'd4
    } mem_arb_state_t;

endpackage

// File: rtl/mem_bus_arbiter.sv
// Shares one external burst memory port between icache refills and dcache
// traffic. One transaction in flight; round-robin between the two caches.
module mem_bus_arbiter
    import cpu_defs::*;
#(
    parameter int LINE_BEATS = cpu_defs::LINE_BEATS,
    parameter int LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ic_req,
    input  logic [31:0]      ic_addr,
    output logic             ic_gnt,
    input  logic             dc_req,
    input  logic             dc_we,
    input  logic             dc_line,
    input  logic [31:0]      dc_addr,
    input  logic [3:0]       dc_wstrb,
    input  logic [31:0]      dc_wdata,
    output logic             dc_gnt,
    output logic             dc_wready,
    output logic             dc_wdone,
    output logic [31:0]      rsp_data,
    output logic             ic_rvalid,
    output logic             dc_rvalid,
    output logic             bus_req,
    output logic             bus_we,
    output logic [31:0]      bus_addr,
    output logic [LEN_W-1:0] bus_len,
    input  logic             bus_ack,
    input  logic [31:0]      bus_rdata,
    input  logic             bus_rvalid,
    output logic [31:0]      bus_wdata,
    output logic [3:0]       bus_wstrb,
    output logic             bus_wvalid,
    input  logic             bus_wready,
    output logic             bus_wlast,
    input  logic             bus_bvalid
);

    localparam logic [LEN_W-1:0] LINE_LEN = LEN_W'(LINE_BEATS - 1);

    mem_arb_state_t   state_r;
    mem_arb_state_t   state_nxt_s;
    mem_port_t        last_grant_r;
    mem_port_t        owner_r;
    logic             we_r;
    logic [31:0]      addr_r;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] count_r;
    logic [3:0]       wstrb_r;
    logic [31:0]      rsp_data_r;
    logic             ic_gnt_r;
    logic             dc_gnt_r;
    logic             ic_rvalid_r;
    logic             dc_rvalid_r;
    logic             dc_wdone_r;
    logic             start_s;
    logic             pick_dc_s;
    logic             last_beat_s;
    logic             rbeat_s;
    logic             wbeat_s;

    assign last_beat_s = (count_r == len_r);
    assign rbeat_s     = (state_r == ARB_RDATA) & bus_rvalid;
    assign wbeat_s     = (state_r == ARB_WDATA) & bus_wready;

    // Arbitration: only in IDLE; on contention the port not served last wins
    always_comb begin
        start_s   = 1'b0;
        pick_dc_s = 1'b0;
        if (state_r == ARB_IDLE) begin
            start_s   = ic_req | dc_req;
            pick_dc_s = dc_req & (~ic_req | (last_grant_r == MEM_PORT_IC));
        end else begin
            start_s   = 1'b0;
            pick_dc_s = 1'b0;
        end
    end

    // Next-state logic for the transaction sequencer
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ARB_IDLE: begin
                if (start_s) state_nxt_s = ARB_ADDR;
                else         state_nxt_s = ARB_IDLE;
            end
            ARB_ADDR: begin
                if (bus_ack) state_nxt_s = we_r ? ARB_WDATA : ARB_RDATA;
                else         state_nxt_s = ARB_ADDR;
            end
            ARB_RDATA: begin
                if (rbeat_s && last_beat_s) state_nxt_s = ARB_IDLE;
                else                        state_nxt_s = ARB_RDATA;
            end
            ARB_WDATA: begin
                if (wbeat_s && last_beat_s) state_nxt_s = ARB_WRESP;
                else                        state_nxt_s = ARB_WDATA;
            end
            ARB_WRESP: begin
                if (bus_bvalid) state_nxt_s = ARB_IDLE;
                else            state_nxt_s = ARB_WRESP;
            end
            default: state_nxt_s = ARB_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ARB_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Latched transaction attributes, beat counter and registered responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_r <= MEM_PORT_IC;
            owner_r      <= MEM_PORT_IC;
            we_r         <= 1'b0;
            addr_r       <= 32'h0000_0000;
            len_r        <= {LEN_W{1'b0}};
            count_r      <= {LEN_W{1'b0}};
            wstrb_r      <= 4'b0000;
            rsp_data_r   <= 32'h0000_0000;
            ic_gnt_r     <= 1'b0;
            dc_gnt_r     <= 1'b0;
            ic_rvalid_r  <= 1'b0;
            dc_rvalid_r  <= 1'b0;
            dc_wdone_r   <= 1'b0;
        end else begin
            ic_gnt_r    <= start_s & ~pick_dc_s;
            dc_gnt_r    <= start_s & pick_dc_s;
            ic_rvalid_r <= rbeat_s & (owner_r == MEM_PORT_IC);
            dc_rvalid_r <= rbeat_s & (owner_r == MEM_PORT_DC);
            dc_wdone_r  <= (state_r == ARB_WRESP) & bus_bvalid;
            if (start_s) begin
                last_grant_r <= pick_dc_s ? MEM_PORT_DC : MEM_PORT_IC;
                owner_r      <= pick_dc_s ? MEM_PORT_DC : MEM_PORT_IC;
                we_r         <= pick_dc_s & dc_we;
                addr_r       <= pick_dc_s ? dc_addr : ic_addr;
                len_r        <= (!pick_dc_s || dc_line) ? LINE_LEN : {LEN_W{1'b0}};
                wstrb_r      <= pick_dc_s ? dc_wstrb : 4'b0000;
            end
            if ((state_r == ARB_ADDR) && bus_ack) begin
                count_r <= {LEN_W{1'b0}};
            end else if (rbeat_s || wbeat_s) begin
                count_r <= count_r + LEN_W'(1);
            end
            if (rbeat_s) begin
                rsp_data_r <= bus_rdata;
            end
        end
    end

    assign ic_gnt     = ic_gnt_r;
    assign dc_gnt     = dc_gnt_r;
    assign ic_rvalid  = ic_rvalid_r;
    assign dc_rvalid  = dc_rvalid_r;
    assign dc_wdone   = dc_wdone_r;
    assign rsp_data   = rsp_data_r;
    assign bus_req    = (state_r == ARB_ADDR);
    assign bus_we     = we_r;
    assign bus_addr   = addr_r;
    assign bus_len    = len_r;
    assign bus_wstrb  = wstrb_r;
    assign bus_wvalid = (state_r == ARB_WDATA);
    assign bus_wlast  = bus_wvalid & last_beat_s;
    assign dc_wready  = bus_wvalid & bus_wready;
    // Write data is a pass-through, forced to zero when no beat is offered
    assign bus_wdata  = bus_wvalid ? dc_wdata : 32'h0000_0000;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_gnt;
    logic        dc_req;
    logic        dc_we;
    logic        dc_line;
    logic [31:0] dc_addr;
    logic [3:0]  dc_wstrb;
    logic [31:0] dc_wdata;
    logic        dc_gnt;
    logic        dc_wready;
    logic        dc_wdone;
    logic [31:0] rsp_data;
    logic        ic_rvalid;
    logic        dc_rvalid;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [7:0]  bus_len;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        bus_rvalid;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_wvalid;
    logic        bus_wready;
    logic        bus_wlast;
    logic        bus_bvalid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.LINE_BEATS(4), .LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .ic_req(ic_req), .ic_addr(ic_addr), .ic_gnt(ic_gnt),
        .dc_req(dc_req), .dc_we(dc_we), .dc_line(dc_line), .dc_addr(dc_addr),
        .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata), .dc_gnt(dc_gnt),
        .dc_wready(dc_wready), .dc_wdone(dc_wdone),
        .rsp_data(rsp_data), .ic_rvalid(ic_rvalid), .dc_rvalid(dc_rvalid),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_len(bus_len),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_rvalid(bus_rvalid),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_wvalid(bus_wvalid),
        .bus_wready(bus_wready), .bus_wlast(bus_wlast), .bus_bvalid(bus_bvalid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ic_gnt"},    {31'd0, ic_gnt},    32'd0);
        check({tag, "_dc_gnt"},    {31'd0, dc_gnt},    32'd0);
        check({tag, "_ic_rvalid"}, {31'd0, ic_rvalid}, 32'd0);
        check({tag, "_dc_rvalid"}, {31'd0, dc_rvalid}, 32'd0);
        check({tag, "_rsp_data"},  rsp_data,           32'd0);
        check({tag, "_bus_req"},   {31'd0, bus_req},   32'd0);
        check({tag, "_bus_we"},    {31'd0, bus_we},    32'd0);
        check({tag, "_bus_addr"},  bus_addr,           32'd0);
        check({tag, "_bus_len"},   {24'd0, bus_len},   32'd0);
        check({tag, "_bus_wvalid"},{31'd0, bus_wvalid},32'd0);
        check({tag, "_bus_wlast"}, {31'd0, bus_wlast}, 32'd0);
        check({tag, "_bus_wstrb"}, {28'd0, bus_wstrb}, 32'd0);
        check({tag, "_bus_wdata"}, bus_wdata,          32'd0);
        check({tag, "_dc_wready"}, {31'd0, dc_wready}, 32'd0);
        check({tag, "_dc_wdone"},  {31'd0, dc_wdone},  32'd0);
    endtask

    // Grant is visible now; verify address phase and drop the winner's request.
    task automatic check_grant(input logic is_ic, input logic [31:0] addr,
                               input logic [7:0] len, input logic we);
        check("gnt_ic",   {31'd0, ic_gnt},  {31'd0, is_ic});
        check("gnt_dc",   {31'd0, dc_gnt},  {31'd0, ~is_ic});
        check("bus_req",  {31'd0, bus_req}, 32'd1);
        check("bus_addr", bus_addr,         addr);
        check("bus_len",  {24'd0, bus_len}, {24'd0, len});
        check("bus_we",   {31'd0, bus_we},  {31'd0, we});
        if (is_ic) ic_req = 1'b0;
        else       dc_req = 1'b0;
    endtask

    task automatic ack_phase();
        bus_ack = 1'b1;
        @(negedge clk);
        bus_ack = 1'b0;
        check("ack_req_low", {31'd0, bus_req}, 32'd0);
        check("ack_gnt_ic",  {31'd0, ic_gnt},  32'd0);
        check("ack_gnt_dc",  {31'd0, dc_gnt},  32'd0);
    endtask

    task automatic read_beats(input int n, input logic to_ic, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = base + 32'(i);
            @(negedge clk);
            check("rd_ic_rvalid", {31'd0, ic_rvalid}, {31'd0, to_ic});
            check("rd_dc_rvalid", {31'd0, dc_rvalid}, {31'd0, ~to_ic});
            check("rd_data",      rsp_data,           base + 32'(i));
        end
        bus_rvalid = 1'b0;
        bus_rdata  = 32'd0;
        @(negedge clk);
        check("rd_end_ic_rvalid", {31'd0, ic_rvalid}, 32'd0);
        check("rd_end_dc_rvalid", {31'd0, dc_rvalid}, 32'd0);
    endtask

    logic [31:0] wd [4];
    int          wpat [5];
    int          beat;
    int          nready;
    int          nlast;

    initial begin
        wd   = '{32'hA0A0_0000, 32'hA1A1_1111, 32'hA2A2_2222, 32'hA3A3_3333};
        wpat = '{1, 0, 1, 1, 1};
        rst_n = 1'b0; ic_req = 1'b0; ic_addr = 32'd0; dc_req = 1'b0; dc_we = 1'b0;
        dc_line = 1'b0; dc_addr = 32'd0; dc_wstrb = 4'd0; dc_wdata = 32'd0;
        bus_ack = 1'b0; bus_rdata = 32'd0; bus_rvalid = 1'b0; bus_wready = 1'b0;
        bus_bvalid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Both request together after reset: dc first, then ic; dc re-requests meanwhile
        ic_req = 1'b1; ic_addr = 32'h1C00_0200;
        dc_req = 1'b1; dc_we = 1'b0; dc_line = 1'b1; dc_addr = 32'h2000_0040;
        @(negedge clk);
        check_grant(1'b0, 32'h2000_0040, 8'd3, 1'b0);
        ack_phase();
        dc_req = 1'b1; dc_line = 1'b0; dc_addr = 32'h3000_0004;
        read_beats(4, 1'b0, 32'hD000_0000);
        check_grant(1'b1, 32'h1C00_0200, 8'd3, 1'b0);
        ack_phase();
        read_beats(4, 1'b1, 32'hC000_0010);
        check_grant(1'b0, 32'h3000_0004, 8'd0, 1'b0);
        ack_phase();
        read_beats(1, 1'b0, 32'h5555_AAAA);

        // icache refill alone
        ic_req = 1'b1; ic_addr = 32'h1C00_0100;
        @(negedge clk);
        check_grant(1'b1, 32'h1C00_0100, 8'd3, 1'b0);
        ack_phase();
        read_beats(4, 1'b1, 32'hD0D0_0000);

        // dcache line write with a stalled beat
        dc_req = 1'b1; dc_we = 1'b1; dc_line = 1'b1; dc_addr = 32'h4000_0080;
        dc_wstrb = 4'hF; dc_wdata = wd[0];
        @(negedge clk);
        check_grant(1'b0, 32'h4000_0080, 8'd3, 1'b1);
        check("wr_wstrb", {28'd0, bus_wstrb}, 32'hF);
        ack_phase();
        beat = 0; nready = 0; nlast = 0;
        for (int k = 0; k < 5; k++) begin
            bus_wready = wpat[k][0];
            dc_wdata   = wd[beat];
            #1;
            check("wr_wvalid", {31'd0, bus_wvalid}, 32'd1);
            check("wr_wdata",  bus_wdata,           wd[beat]);
            check("wr_wlast",  {31'd0, bus_wlast},  (beat == 3) ? 32'd1 : 32'd0);
            check("wr_wready", {31'd0, dc_wready},  32'(wpat[k]));
            if (dc_wready) nready++;
            if (dc_wready && bus_wlast) nlast++;
            if (wpat[k] == 1) beat++;
            @(negedge clk);
        end
        bus_wready = 1'b0;
        check("wr_ready_count", 32'(nready), 32'd4);
        check("wr_last_count",  32'(nlast),  32'd1);
        check("wr_resp_wvalid", {31'd0, bus_wvalid}, 32'd0);
        check("wr_wdone_early", {31'd0, dc_wdone},   32'd0);
        bus_bvalid = 1'b1;
        @(negedge clk);
        bus_bvalid = 1'b0;
        check("wr_wdone",       {31'd0, dc_wdone}, 32'd1);
        @(negedge clk);
        check("wr_wdone_pulse", {31'd0, dc_wdone}, 32'd0);

        // Uncached single-beat store
        dc_req = 1'b1; dc_we = 1'b1; dc_line = 1'b0; dc_addr = 32'h5000_0002;
        dc_wstrb = 4'b0010; dc_wdata = 32'h0000_BE00;
        @(negedge clk);
        check_grant(1'b0, 32'h5000_0002, 8'd0, 1'b1);
        check("st_wstrb", {28'd0, bus_wstrb}, 32'h2);
        ack_phase();
        bus_wready = 1'b1;
        #1;
        check("st_wvalid", {31'd0, bus_wvalid}, 32'd1);
        check("st_wlast",  {31'd0, bus_wlast},  32'd1);
        check("st_wready", {31'd0, dc_wready},  32'd1);
        check("st_wdata",  bus_wdata,           32'h0000_BE00);
        @(negedge clk);
        bus_wready = 1'b0;
        check("st_wvalid_off", {31'd0, bus_wvalid}, 32'd0);
        bus_bvalid = 1'b1;
        @(negedge clk);
        bus_bvalid = 1'b0;
        check("st_wdone", {31'd0, dc_wdone}, 32'd1);
        @(negedge clk);
        check("st_wdone_pulse", {31'd0, dc_wdone}, 32'd0);

        // Delayed ack with a dcache request queued behind it
        ic_req = 1'b1; ic_addr = 32'h1C00_0300;
        @(negedge clk);
        check_grant(1'b1, 32'h1C00_0300, 8'd3, 1'b0);
        dc_req = 1'b1; dc_we = 1'b0; dc_line = 1'b0; dc_addr = 32'h6000_0010;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_req",    {31'd0, bus_req}, 32'd1);
            check("hold_addr",   bus_addr,         32'h1C00_0300);
            check("hold_len",    {24'd0, bus_len}, 32'd3);
            check("hold_dc_gnt", {31'd0, dc_gnt},  32'd0);
        end
        ack_phase();
        read_beats(4, 1'b1, 32'hE000_0000);
        check_grant(1'b0, 32'h6000_0010, 8'd0, 1'b0);
        ack_phase();
        read_beats(1, 1'b0, 32'h7777_0001);

        // Reset in the middle of a refill burst
        ic_req = 1'b1; ic_addr = 32'h1C00_0400;
        @(negedge clk);
        check_grant(1'b1, 32'h1C00_0400, 8'd3, 1'b0);
        ack_phase();
        for (int i = 0; i < 2; i++) begin
            bus_rvalid = 1'b1;
            bus_rdata  = 32'hF000_0000 + 32'(i);
            @(negedge clk);
        end
        check("mid_rvalid_pre", {31'd0, ic_rvalid}, 32'd1);
        bus_rdata = 32'hF000_0002;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        bus_rvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hBAD0_BAD0;
        @(negedge clk);
        @(negedge clk);
        check("stray_ic_rvalid", {31'd0, ic_rvalid}, 32'd0);
        check("stray_dc_rvalid", {31'd0, dc_rvalid}, 32'd0);
        check("stray_rsp_data",  rsp_data,           32'd0);
        check("stray_bus_req",   {31'd0, bus_req},   32'd0);
        bus_rvalid = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
